test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
- Hardware scheduler for the unit-test harness.
- Runs NUM_TESTS self-checking test units one at a time. Each unit exposes done/result_out.
- Gives each unit an exclusive start window with a cycle watchdog, and records a per-test fail/timeout mask.
- Drives one aggregate pass/all_done pair, so the bench top (or an on-FPGA self-test) needs no concurrent OR/AND merging.

Parameters:
NUM_TESTS, 5, number of test units sequenced (1..16)
TIMEOUT_CYCLES, 1024, max RUN cycles per test before declaring timeout (>=2)
IDX_W, 4, width of current_index (must satisfy 2^IDX_W >= NUM_TESTS)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  synchronous active-low reset
go  input  1  start a full sequence; sampled only in IDLE
test_done  input  NUM_TESTS  per-unit done flag (unit's done output)
test_result  input  NUM_TESTS  per-unit result_out, 1 = failure
test_start  output  NUM_TESTS  one-hot enable to the unit under test; all-zero otherwise
current_index  output  IDX_W  index of test being run or last run
busy  output  1  high from the cycle after go until the FINISH cycle
fail_mask  output  NUM_TESTS  bit i set = test i failed or timed out
timeout_mask  output  NUM_TESTS  bit i set = test i timed out
all_done  output  1  sequence complete; held until next accepted go
pass  output  1  valid when all_done; 1 iff fail_mask == 0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- All outputs are registered.
- Reset (rst_n=0 at an edge): state=IDLE. test_start, current_index, busy, fail_mask, timeout_mask, all_done and pass all go to 0; timer=0. Reset mid-sequence aborts immediately; no partial results are retained.
- States: IDLE, RUN, GAP, FINISH.
- IDLE:
  - go=1 at edge k: fail_mask, timeout_mask, all_done and pass are cleared; current_index=0; timer=0; test_start=1<<0; busy=1; state=RUN. All take effect after edge k.
  - go=0: hold. all_done, pass and masks keep their last values.
- RUN: timer increments by 1 each edge. At each edge, with i=current_index:
  - test_done[i]=1: fail_mask[i]<=test_result[i]; test_start<=0; state=GAP.
  - Else if timer==TIMEOUT_CYCLES-1: fail_mask[i]<=1; timeout_mask[i]<=1; test_start<=0; state=GAP.
  - Done and timeout in the same cycle: done wins; timeout_mask[i] stays 0.
  - test_done/test_result bits of non-selected tests are ignored.
  - Timer is TIMEOUT_CYCLES-bit-safe (width clog2(TIMEOUT_CYCLES)+1) and never wraps inside RUN.
- GAP: exactly one cycle with test_start all-zero, so the finished unit sees start drop. At its edge:
  - If i==NUM_TESTS-1: state=FINISH.
  - Else: current_index<=i+1; timer<=0; test_start<=1<<(i+1); state=RUN.
- FINISH: one cycle. At its edge: all_done<=1; pass<=~|fail_mask; busy<=0; state=IDLE. current_index stays NUM_TESTS-1.
- go is ignored in RUN, GAP and FINISH. It is accepted again only in IDLE, including the cycle right after FINISH.
- Invariant: at most one test_start bit is high; test_start is never high outside RUN.
- Latency, with test i asserting done d cycles after its start rises (d>=1): that test's slot is d+1 cycles (d RUN cycles + 1 GAP).
- Total cycles from go to all_done high = 1 + sum(d_i + 1) + 1.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, go=0 → all outputs 0, test_start=0 indefinitely.
2. All pass, NUM_TESTS=5, every unit asserts done 3 cycles after start with result=0, go pulsed at edge 0 → test_start walks 00001→00010→…→10000. Each bit is high 3 cycles, separated by 1 zero cycle. all_done=1 and pass=1 after edge 21; fail_mask=0.
3. Single failure: test 2 returns result=1 → fail_mask=00100, timeout_mask=0, pass=0. Remaining tests still run.
4. Timeout, TIMEOUT_CYCLES=8: test 3 never asserts done → start[3] high exactly 8 cycles. fail_mask=01000, timeout_mask=01000, sequence continues to test 4.
5. Boundary and priority: test 1 asserts done on the cycle where timer==TIMEOUT_CYCLES-1 → no timeout bit set, fail_mask[1]=result. Also, done asserted on a non-selected test during test 0 → ignored.
6. Abort and restart: rst_n=0 while test 2 is running → next cycle all outputs 0. go during RUN is ignored. go in IDLE after a failing run clears fail_mask before the new sequence starts.

Source files
------------

// File: rtl/test_sequencer.sv
// Runs the test units one at a time, each with a start window and a watchdog.
// Collects per-test fail/timeout masks and reports one pass/all_done pair.
module test_sequencer #(
   parameter int NUM_TESTS      = 5,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int IDX_W          = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go,
   input  logic [NUM_TESTS-1:0] test_done,
   input  logic [NUM_TESTS-1:0] test_result,
   output logic [NUM_TESTS-1:0] test_start,
   output logic [IDX_W-1:0]     current_index,
   output logic                 busy,
   output logic [NUM_TESTS-1:0] fail_mask,
   output logic [NUM_TESTS-1:0] timeout_mask,
   output logic                 all_done,
   output logic                 pass
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, RUN, GAP, FINISH} state_t;

   state_t               state_q, state_d;
   logic [NUM_TESTS-1:0] start_q, start_d;
   logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
   logic                 busy_q, busy_d;
   logic [NUM_TESTS-1:0] fail_q, fail_d;
   logic [NUM_TESTS-1:0] to_q, to_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 sel_done;
   logic                 last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         fail_q  <= '0;
         to_q    <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         fail_q  <= fail_d;
         to_q    <= to_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         timer_q <= timer_d;
      end
   end

   // start_q is one-hot on the running unit, so it doubles as the selector
   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      fail_d   = fail_q;
      to_d     = to_q;
      done_d   = done_q;
      pass_d   = pass_q;
      timer_d  = timer_q;
      sel_done = |(test_done & start_q);
      idx_inc  = idx_q + IDX_W'(1);
      last     = (idx_q == IDX_W'(NUM_TESTS - 1));
      unique case (state_q)
         IDLE: begin
            if (go) begin
               fail_d  = '0;
               to_d    = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               idx_d   = '0;
               timer_d = '0;
               start_d = NUM_TESTS'(1);
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            timer_d = timer_q + TW'(1);
            if (sel_done) begin
               fail_d  = (fail_q & ~start_q) | (test_result & start_q);
               start_d = '0;
               state_d = GAP;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               fail_d  = fail_q | start_q;
               to_d    = to_q | start_q;
               start_d = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (last) begin
               state_d = FINISH;
            end else begin
               idx_d   = idx_inc;
               timer_d = '0;
               start_d = NUM_TESTS'(1) << idx_inc;
               state_d = RUN;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            pass_d  = ~|fail_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign test_start    = start_q;
   assign current_index = idx_q;
   assign busy          = busy_q;
   assign fail_mask     = fail_q;
   assign timeout_mask  = to_q;
   assign all_done      = done_q;
   assign pass          = pass_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed vector bench for test_sequencer with behavioural test-unit models.
// Each unit raises done a programmed number of cycles after its start rises.
module tb_test_sequencer;

   localparam int N  = 5;
   localparam int TO = 8;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          go;
   logic [N-1:0]  test_done;
   logic [N-1:0]  test_result;
   logic [N-1:0]  test_start;
   logic [IW-1:0] current_index;
   logic          busy;
   logic [N-1:0]  fail_mask;
   logic [N-1:0]  timeout_mask;
   logic          all_done;
   logic          pass;

   int checks   = 0;
   int failures = 0;

   test_sequencer #(
      .NUM_TESTS(N),
      .TIMEOUT_CYCLES(TO),
      .IDX_W(IW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .go(go),
      .test_done(test_done),
      .test_result(test_result),
      .test_start(test_start),
      .current_index(current_index),
      .busy(busy),
      .fail_mask(fail_mask),
      .timeout_mask(timeout_mask),
      .all_done(all_done),
      .pass(pass)
   );

   always #5 clk = ~clk;

   // unit models: delay nibble 0 means the unit never finishes
   logic [19:0]  cur_d    = '0;
   logic [N-1:0] cur_res  = '0;
   logic [N-1:0] cur_spur = '0;
   logic [3:0]   cnt [N];
   logic [N-1:0] mdone;
   int           hi_tot [N];
   bit           armed = 1'b0;

   initial begin
      for (int i = 0; i < N; i++) begin
         cnt[i]    = '0;
         hi_tot[i] = 0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         cnt[i] <= test_start[i] ? cnt[i] + 4'd1 : 4'd0;
         if (test_start[i] === 1'b1) hi_tot[i] = hi_tot[i] + 1;
      end
   end

   always_comb begin
      mdone = '0;
      for (int i = 0; i < N; i++)
         mdone[i] = test_start[i] && (cur_d[4*i +: 4] != 4'd0) &&
                    (cnt[i] == cur_d[4*i +: 4] - 4'd1);
      test_done   = mdone | (cur_spur & ~test_start);
      test_result = (cur_res & test_start) | (cur_spur & ~test_start);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // one-hot-or-zero start, and no start while not busy
   always @(negedge clk) begin
      if (armed) begin
         checks++;
         if (($countones(test_start) > 1) || (!busy && test_start != '0)) begin
            failures++;
            $display("FAIL start_invariant actual=%0h expected=onehot0", test_start);
         end
      end
   end

   function automatic logic [21:0] outs();
      return {test_start, current_index, busy, fail_mask, timeout_mask,
              all_done, pass};
   endfunction

   typedef struct {
      logic [19:0]  d;
      logic [N-1:0] res;
      logic [N-1:0] spur;
      bit           extra_go;
      logic [N-1:0] ef;
      logic [N-1:0] et;
      logic         ep;
      int           ecyc;
   } vec_t;

   vec_t vecs [6];

   task automatic run_seq(input vec_t v, input int vn);
      int base [N];
      int edges;
      int exp_hi;
      cur_d    = v.d;
      cur_res  = v.res;
      cur_spur = v.spur;
      for (int i = 0; i < N; i++) base[i] = hi_tot[i];
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk($sformatf("v%0d_after_go", vn), 32'(outs()),
          32'({5'b00001, 4'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0}));
      edges = 0;
      while (!all_done && edges < 200) begin
         go = (v.extra_go && edges == 2);
         @(negedge clk);
         edges++;
      end
      go = 1'b0;
      chk($sformatf("v%0d_cycles", vn), 32'(edges), 32'(v.ecyc));
      chk($sformatf("v%0d_fail_mask", vn), 32'(fail_mask), 32'(v.ef));
      chk($sformatf("v%0d_timeout_mask", vn), 32'(timeout_mask), 32'(v.et));
      chk($sformatf("v%0d_pass", vn), 32'(pass), 32'(v.ep));
      chk($sformatf("v%0d_idle_idx", vn), 32'({busy, current_index}),
          32'({1'b0, 4'd4}));
      for (int i = 0; i < N; i++) begin
         exp_hi = (v.d[4*i +: 4] == 4'd0) ? TO : int'(v.d[4*i +: 4]);
         chk($sformatf("v%0d_start%0d_width", vn, i),
             32'(hi_tot[i] - base[i]), 32'(exp_hi));
      end
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_hold", vn), 32'({all_done, pass, fail_mask}),
          32'({1'b1, v.ep, v.ef}));
   endtask

   initial begin
      int waited;
      vecs[0] = '{20'h33333, 5'b00000, 5'b00000, 1'b0,
                  5'b00000, 5'b00000, 1'b1, 21};
      vecs[1] = '{20'h33333, 5'b00100, 5'b11111, 1'b1,
                  5'b00100, 5'b00000, 1'b0, 21};
      vecs[2] = '{20'h20321, 5'b00000, 5'b00000, 1'b0,
                  5'b01000, 5'b01000, 1'b0, 22};
      vecs[3] = '{20'h11181, 5'b00010, 5'b00000, 1'b0,
                  5'b00010, 5'b00000, 1'b0, 18};
      vecs[4] = '{20'h11181, 5'b00000, 5'b11111, 1'b0,
                  5'b00000, 5'b00000, 1'b1, 18};
      vecs[5] = '{20'h00000, 5'b00000, 5'b00000, 1'b0,
                  5'b11111, 5'b11111, 1'b0, 46};

      rst_n = 1'b0;
      go    = 1'b0;
      repeat (2) @(negedge clk);
      armed = 1'b1;
      chk("reset_outputs", 32'(outs()), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_outputs", 32'(outs()), 32'd0);

      for (int v = 0; v < 6; v++) run_seq(vecs[v], v);

      // abort while test 2 is running, after a failing run left masks set
      cur_d    = 20'h33333;
      cur_res  = 5'b00000;
      cur_spur = 5'b00000;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      waited = 0;
      while (test_start !== 5'b00100 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("abort_reach_test2", 32'(test_start), 32'b00100);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_outputs", 32'(outs()), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_idle", 32'(outs()), 32'd0);

      run_seq(vecs[0], 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
